// File: rtl/solo_squash_input_conditioner_if.sv
// Raw button/status inputs and conditioned levels between the GPIO pads and the
// solo_squash input conditioner. The game-side wrapper uses master; the conditioner uses slave.
interface solo_squash_input_conditioner_if;
  logic gpio_ready;
  logic ext_reset_n;
  logic pause_n;
  logic new_game_n;
  logic down_key_n;
  logic up_key_n;
  logic design_reset;
  logic pause;
  logic new_game;
  logic down_key;
  logic up_key;
  logic new_game_pulse;
  logic debug_gpio_ready;

  modport master (
    output gpio_ready, ext_reset_n, pause_n, new_game_n, down_key_n, up_key_n,
    input  design_reset, pause, new_game, down_key, up_key, new_game_pulse, debug_gpio_ready
  );

  modport slave (
    input  gpio_ready, ext_reset_n, pause_n, new_game_n, down_key_n, up_key_n,
    output design_reset, pause, new_game, down_key, up_key, new_game_pulse, debug_gpio_ready
  );
endinterface

// File: rtl/solo_squash_input_conditioner.sv
// Synchronises and debounces the solo_squash buttons and sequences the game reset.
// Define SOLO_SQUASH_DEBOUNCE_EN to build the debouncers; otherwise buttons are only synchronised.
module solo_squash_input_conditioner #(
  parameter int DEBOUNCE_LIMIT = 50000,
  parameter int CNT_W          = 16,
  parameter int RESET_HOLD     = 16
) (
  input logic                            wb_clk_i,
  input logic                            wb_rst_i,
  solo_squash_input_conditioner_if.slave bus
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  // Bit order: pause_n, new_game_n, down_key_n, up_key_n, ext_reset_n, gpio_ready.
  localparam logic [5:0] SYNC_IDLE = 6'b01_1111;

  typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_RUN} state_t;

  if (DEBOUNCE_LIMIT < 2 || (2 ** CNT_W) <= DEBOUNCE_LIMIT || RESET_HOLD < 1) begin : g_bad_params
    $error("solo_squash_input_conditioner: illegal DEBOUNCE_LIMIT/CNT_W/RESET_HOLD");
  end

  logic [5:0]        w_raw;
  logic [5:0]        r_meta;
  logic [5:0]        r_sync;
  logic [3:0]        w_btn;
  logic              w_release_ok;
  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_design_reset;
  logic              r_new_game_d;

  assign w_raw = {bus.gpio_ready, bus.ext_reset_n, bus.up_key_n,
                  bus.down_key_n, bus.new_game_n, bus.pause_n};

  // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_meta <= SYNC_IDLE;
      r_sync <= SYNC_IDLE;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

`ifdef SOLO_SQUASH_DEBOUNCE_EN
  logic [3:0]       r_stable;
  logic [CNT_W-1:0] r_cnt [4];

  // Counter clears before it can reach DEBOUNCE_LIMIT, so it never wraps.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_stable <= 4'b1111;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_btn = ~r_stable;
`else
  assign w_btn = ~r_sync[3:0];
`endif

  assign w_release_ok = r_sync[5] & r_sync[4];

  // A failed release condition beats the stretch counter in every state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state        <= S_HOLD;
      r_hold_cnt     <= '0;
      r_design_reset <= 1'b1;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_design_reset <= 1'b1;
          if (w_release_ok) begin
            r_state    <= S_STRETCH;
            r_hold_cnt <= HOLD_W'(RESET_HOLD - 1);
          end
        end
        S_STRETCH: begin
          if (!w_release_ok) begin
            r_state        <= S_HOLD;
            r_design_reset <= 1'b1;
          end else if (r_hold_cnt == '0) begin
            r_state        <= S_RUN;
            r_design_reset <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (!w_release_ok) begin
            r_state        <= S_HOLD;
            r_design_reset <= 1'b1;
          end
        end
        default: begin
          r_state        <= S_HOLD;
          r_design_reset <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_new_game_d <= 1'b0;
    else          r_new_game_d <= w_btn[1];
  end

  assign bus.pause            = w_btn[0];
  assign bus.new_game         = w_btn[1];
  assign bus.down_key         = w_btn[2];
  assign bus.up_key           = w_btn[3];
  assign bus.design_reset     = r_design_reset;
  assign bus.debug_gpio_ready = r_sync[5];
  // Presses that complete while the core is held in reset are dropped, not deferred.
  assign bus.new_game_pulse   = w_btn[1] & ~r_new_game_d & ~r_design_reset;

endmodule
